// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs
//   Forward pipeline boundary registers of the 5-stage 64-bit CPU:
//   IF/ID, ID/EX and EX/MEM.
//
//   Each group is a bank of D registers with its own capture enable.
//   When the enable is low the group holds its contents, which is how a stall works.
//   rst (asynchronous, active-high) clears every register.
//   All-zero contents form a bubble: no RegWrite, no MemWrite, no MemRead and no branch.
//   There is no combinational path from any input to any output.
//
// Ports
//   clk, rst                        clock, async active-high reset
//   ifid_en / ifid_*                IF/ID enable, instruction and PC in
//   ifid_*_out                      registered IF/ID fields
//   idex_en / idex_*                ID/EX enable, operands, PC, immediate,
//                                   register indices, EX/M/WB controls
//   idex_*_out                      registered ID/EX fields
//   exmem_en / exmem_*              EX/MEM enable, ALU result, store data,
//                                   branch target, rd, WB/M controls, flags
//   exmem_*_out                     registered EX/MEM fields
module pipeline_stage_regs #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned REG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  // IF/ID
  input  logic               ifid_en,
  input  logic [INSTR_W-1:0] ifid_instr,
  input  logic [DATA_W-1:0]  ifid_pcaddr,
  output logic [INSTR_W-1:0] ifid_instr_out,
  output logic [DATA_W-1:0]  ifid_pcaddr_out,
  // ID/EX
  input  logic               idex_en,
  input  logic [DATA_W-1:0]  idex_rd1,
  input  logic [DATA_W-1:0]  idex_rd2,
  input  logic [DATA_W-1:0]  idex_pcaddr,
  input  logic [DATA_W-1:0]  idex_se,
  input  logic [REG_W-1:0]   idex_rn,
  input  logic [REG_W-1:0]   idex_rm,
  input  logic [REG_W-1:0]   idex_rd,
  input  logic [5:0]         idex_cntrl_ex,
  input  logic [4:0]         idex_cntrl_m,
  input  logic [1:0]         idex_cntrl_wb,
  output logic [DATA_W-1:0]  idex_rd1_out,
  output logic [DATA_W-1:0]  idex_rd2_out,
  output logic [DATA_W-1:0]  idex_pcaddr_out,
  output logic [DATA_W-1:0]  idex_se_out,
  output logic [REG_W-1:0]   idex_rn_out,
  output logic [REG_W-1:0]   idex_rm_out,
  output logic [REG_W-1:0]   idex_rd_out,
  output logic [5:0]         idex_cntrl_ex_out,
  output logic [4:0]         idex_cntrl_m_out,
  output logic [1:0]         idex_cntrl_wb_out,
  // EX/MEM
  input  logic               exmem_en,
  input  logic [DATA_W-1:0]  exmem_aluresult,
  input  logic [DATA_W-1:0]  exmem_writedata,
  input  logic [DATA_W-1:0]  exmem_addr,
  input  logic [REG_W-1:0]   exmem_rd,
  input  logic [1:0]         exmem_wb,
  input  logic [4:0]         exmem_m,
  input  logic [3:0]         exmem_alu_flag,
  input  logic [3:0]         exmem_flag,
  output logic [DATA_W-1:0]  exmem_aluresult_out,
  output logic [DATA_W-1:0]  exmem_writedata_out,
  output logic [DATA_W-1:0]  exmem_addr_out,
  output logic [REG_W-1:0]   exmem_rd_out,
  output logic [1:0]         exmem_wb_out,
  output logic [4:0]         exmem_m_out,
  output logic [3:0]         exmem_alu_flag_out,
  output logic [3:0]         exmem_flag_out
);

  // Each group is held as one packed word.
  // The concatenation order is the same on the capture side and the output side,
  // so every field keeps its bit positions.
  localparam int unsigned IFID_W  = INSTR_W + DATA_W;
  localparam int unsigned IDEX_W  = 4 * DATA_W + 3 * REG_W + 6 + 5 + 2;
  localparam int unsigned EXMEM_W = 3 * DATA_W + REG_W + 2 + 5 + 4 + 4;

  logic [IFID_W-1:0]  ifid_d,  ifid_q;
  logic [IDEX_W-1:0]  idex_d,  idex_q;
  logic [EXMEM_W-1:0] exmem_d, exmem_q;

  always_comb begin
    ifid_d = ifid_q;
    if (ifid_en) begin
      ifid_d = {ifid_instr, ifid_pcaddr};
    end
  end

  always_comb begin
    idex_d = idex_q;
    if (idex_en) begin
      idex_d = {idex_rd1, idex_rd2, idex_pcaddr, idex_se,
                idex_rn, idex_rm, idex_rd,
                idex_cntrl_ex, idex_cntrl_m, idex_cntrl_wb};
    end
  end

  always_comb begin
    exmem_d = exmem_q;
    if (exmem_en) begin
      exmem_d = {exmem_aluresult, exmem_writedata, exmem_addr, exmem_rd,
                 exmem_wb, exmem_m, exmem_alu_flag, exmem_flag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign {ifid_instr_out, ifid_pcaddr_out} = ifid_q;

  assign {idex_rd1_out, idex_rd2_out, idex_pcaddr_out, idex_se_out,
          idex_rn_out, idex_rm_out, idex_rd_out,
          idex_cntrl_ex_out, idex_cntrl_m_out, idex_cntrl_wb_out} = idex_q;

  assign {exmem_aluresult_out, exmem_writedata_out, exmem_addr_out, exmem_rd_out,
          exmem_wb_out, exmem_m_out, exmem_alu_flag_out, exmem_flag_out} = exmem_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
module tb_pipeline_stage_regs;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ifid_en = 1'b0;
  logic [INSTR_W-1:0] ifid_instr = '0;
  logic [DATA_W-1:0]  ifid_pcaddr = '0;
  logic [INSTR_W-1:0] ifid_instr_out;
  logic [DATA_W-1:0]  ifid_pcaddr_out;
  logic               idex_en = 1'b0;
  logic [DATA_W-1:0]  idex_rd1 = '0, idex_rd2 = '0, idex_pcaddr = '0, idex_se = '0;
  logic [REG_W-1:0]   idex_rn = '0, idex_rm = '0, idex_rd = '0;
  logic [5:0]         idex_cntrl_ex = '0;
  logic [4:0]         idex_cntrl_m = '0;
  logic [1:0]         idex_cntrl_wb = '0;
  logic [DATA_W-1:0]  idex_rd1_out, idex_rd2_out, idex_pcaddr_out, idex_se_out;
  logic [REG_W-1:0]   idex_rn_out, idex_rm_out, idex_rd_out;
  logic [5:0]         idex_cntrl_ex_out;
  logic [4:0]         idex_cntrl_m_out;
  logic [1:0]         idex_cntrl_wb_out;
  logic               exmem_en = 1'b0;
  logic [DATA_W-1:0]  exmem_aluresult = '0, exmem_writedata = '0, exmem_addr = '0;
  logic [REG_W-1:0]   exmem_rd = '0;
  logic [1:0]         exmem_wb = '0;
  logic [4:0]         exmem_m = '0;
  logic [3:0]         exmem_alu_flag = '0, exmem_flag = '0;
  logic [DATA_W-1:0]  exmem_aluresult_out, exmem_writedata_out, exmem_addr_out;
  logic [REG_W-1:0]   exmem_rd_out;
  logic [1:0]         exmem_wb_out;
  logic [4:0]         exmem_m_out;
  logic [3:0]         exmem_alu_flag_out, exmem_flag_out;

  int checks = 0;
  int errors = 0;

  pipeline_stage_regs #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .ifid_en(ifid_en), .ifid_instr(ifid_instr), .ifid_pcaddr(ifid_pcaddr),
    .ifid_instr_out(ifid_instr_out), .ifid_pcaddr_out(ifid_pcaddr_out),
    .idex_en(idex_en), .idex_rd1(idex_rd1), .idex_rd2(idex_rd2),
    .idex_pcaddr(idex_pcaddr), .idex_se(idex_se),
    .idex_rn(idex_rn), .idex_rm(idex_rm), .idex_rd(idex_rd),
    .idex_cntrl_ex(idex_cntrl_ex), .idex_cntrl_m(idex_cntrl_m), .idex_cntrl_wb(idex_cntrl_wb),
    .idex_rd1_out(idex_rd1_out), .idex_rd2_out(idex_rd2_out),
    .idex_pcaddr_out(idex_pcaddr_out), .idex_se_out(idex_se_out),
    .idex_rn_out(idex_rn_out), .idex_rm_out(idex_rm_out), .idex_rd_out(idex_rd_out),
    .idex_cntrl_ex_out(idex_cntrl_ex_out), .idex_cntrl_m_out(idex_cntrl_m_out),
    .idex_cntrl_wb_out(idex_cntrl_wb_out),
    .exmem_en(exmem_en), .exmem_aluresult(exmem_aluresult),
    .exmem_writedata(exmem_writedata), .exmem_addr(exmem_addr), .exmem_rd(exmem_rd),
    .exmem_wb(exmem_wb), .exmem_m(exmem_m),
    .exmem_alu_flag(exmem_alu_flag), .exmem_flag(exmem_flag),
    .exmem_aluresult_out(exmem_aluresult_out), .exmem_writedata_out(exmem_writedata_out),
    .exmem_addr_out(exmem_addr_out), .exmem_rd_out(exmem_rd_out),
    .exmem_wb_out(exmem_wb_out), .exmem_m_out(exmem_m_out),
    .exmem_alu_flag_out(exmem_alu_flag_out), .exmem_flag_out(exmem_flag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ifid_instr"},   64'(ifid_instr_out), '0);
    check({tag, " ifid_pc"},      ifid_pcaddr_out, '0);
    check({tag, " idex_rd1"},     idex_rd1_out, '0);
    check({tag, " idex_rd2"},     idex_rd2_out, '0);
    check({tag, " idex_pc"},      idex_pcaddr_out, '0);
    check({tag, " idex_se"},      idex_se_out, '0);
    check({tag, " idex_regs"},    64'({idex_rn_out, idex_rm_out, idex_rd_out}), '0);
    check({tag, " idex_ctl"},     64'({idex_cntrl_ex_out, idex_cntrl_m_out, idex_cntrl_wb_out}), '0);
    check({tag, " exmem_alu"},    exmem_aluresult_out, '0);
    check({tag, " exmem_wdata"},  exmem_writedata_out, '0);
    check({tag, " exmem_addr"},   exmem_addr_out, '0);
    check({tag, " exmem_misc"},   64'({exmem_rd_out, exmem_wb_out, exmem_m_out,
                                        exmem_alu_flag_out, exmem_flag_out}), '0);
  endtask

  // Nonzero pseudo-random values on every data input.
  task automatic drive_random();
    ifid_instr      = $urandom | 32'h1;
    ifid_pcaddr     = {32'($urandom), 32'($urandom)} | 64'h1;
    idex_rd1        = {32'($urandom), 32'($urandom)} | 64'h1;
    idex_rd2        = {32'($urandom), 32'($urandom)} | 64'h1;
    idex_pcaddr     = {32'($urandom), 32'($urandom)} | 64'h1;
    idex_se         = {32'($urandom), 32'($urandom)} | 64'h1;
    idex_rn         = 5'h11; idex_rm = 5'h0A; idex_rd = 5'h1F;
    idex_cntrl_ex   = 6'h3F; idex_cntrl_m = 5'h1F; idex_cntrl_wb = 2'h3;
    exmem_aluresult = {32'($urandom), 32'($urandom)} | 64'h1;
    exmem_writedata = {32'($urandom), 32'($urandom)} | 64'h1;
    exmem_addr      = {32'($urandom), 32'($urandom)} | 64'h1;
    exmem_rd        = 5'h15; exmem_wb = 2'h3; exmem_m = 5'h1F;
    exmem_alu_flag  = 4'hF; exmem_flag = 4'hF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [INSTR_W-1:0] flow_instr [5];
  logic [DATA_W-1:0]  flow_pc    [5];

  initial begin
    // Reset asserted between edges clears already-loaded registers at once
    #2;
    rst = 1'b0;
    drive_random();
    ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1;
    tick();
    check("preload idex_se nonzero", 64'(idex_se_out != '0), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    tick();
    check_all_zero("rst_hold");

    // IF/ID capture
    @(negedge clk);
    rst = 1'b0;
    ifid_en = 1'b1; idex_en = 1'b0; exmem_en = 1'b0;
    ifid_instr = 32'hF8400041;
    ifid_pcaddr = 64'h10;
    #1;
    check("ifid before edge", 64'(ifid_instr_out), 64'h0);
    tick();
    check("ifid_instr", 64'(ifid_instr_out), 64'h00000000F8400041);
    check("ifid_pc", ifid_pcaddr_out, 64'h10);
    check("idex held at 0 while disabled", idex_rd1_out, 64'h0);

    // ID/EX capture, then stall
    @(negedge clk);
    ifid_en = 1'b0; idex_en = 1'b1;
    idex_rd1 = 64'd5; idex_rd2 = 64'hFFFF_FFFF_FFFF_FFFB;
    idex_pcaddr = 64'h14; idex_se = 64'h8;
    idex_rn = 5'd1; idex_rm = 5'd2; idex_rd = 5'd3;
    idex_cntrl_ex = 6'b101010; idex_cntrl_m = 5'b10100; idex_cntrl_wb = 2'b10;
    ifid_instr = 32'hDEADBEEF;
    tick();
    check("idex_rd1", idex_rd1_out, 64'd5);
    check("idex_rd2", idex_rd2_out, 64'hFFFF_FFFF_FFFF_FFFB);
    check("idex_pc", idex_pcaddr_out, 64'h14);
    check("idex_se", idex_se_out, 64'h8);
    check("idex_rn", 64'(idex_rn_out), 64'd1);
    check("idex_rm", 64'(idex_rm_out), 64'd2);
    check("idex_rd", 64'(idex_rd_out), 64'd3);
    check("idex_ex", 64'(idex_cntrl_ex_out), 64'h2A);
    check("idex_m", 64'(idex_cntrl_m_out), 64'h14);
    check("idex_wb", 64'(idex_cntrl_wb_out), 64'h2);
    check("ifid stalled", 64'(ifid_instr_out), 64'h00000000F8400041);
    @(negedge clk);
    idex_en = 1'b0;
    idex_rd1 = 64'h77; idex_rd2 = 64'h1; idex_pcaddr = 64'h99; idex_se = 64'hABC;
    idex_rn = 5'd9; idex_rm = 5'd10; idex_rd = 5'd11;
    idex_cntrl_ex = 6'b010101; idex_cntrl_m = 5'b01011; idex_cntrl_wb = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idex stall rd1", idex_rd1_out, 64'd5);
      check("idex stall ctl", 64'({idex_cntrl_ex_out, idex_cntrl_m_out, idex_cntrl_wb_out}),
            64'({6'b101010, 5'b10100, 2'b10}));
      check("idex stall regs", 64'({idex_rn_out, idex_rm_out, idex_rd_out}),
            64'({5'd1, 5'd2, 5'd3}));
    end

    // EX/MEM capture, flag ordering
    @(negedge clk);
    exmem_en = 1'b1;
    exmem_alu_flag = 4'b1010; exmem_flag = 4'b0101;
    exmem_aluresult = 64'h20; exmem_writedata = 64'h1234; exmem_addr = 64'h40;
    exmem_rd = 5'd31; exmem_m = 5'b00010; exmem_wb = 2'b00;
    tick();
    check("exmem_alu_flag", 64'(exmem_alu_flag_out), 64'hA);
    check("exmem_flag", 64'(exmem_flag_out), 64'h5);
    check("exmem_aluresult", exmem_aluresult_out, 64'h20);
    check("exmem_wdata", exmem_writedata_out, 64'h1234);
    check("exmem_addr", exmem_addr_out, 64'h40);
    check("exmem_rd", 64'(exmem_rd_out), 64'd31);
    check("exmem_m", 64'(exmem_m_out), 64'h02);
    check("exmem_wb", 64'(exmem_wb_out), 64'h0);
    check("idex still stalled", idex_se_out, 64'h8);

    // Pipeline flow: one new IF/ID word per cycle, each visible one edge later
    for (int i = 0; i < 5; i++) begin
      flow_instr[i] = 32'h1000_0000 + 32'(i * 3 + 1);
      flow_pc[i]    = 64'h100 + 64'(i * 4);
    end
    @(negedge clk);
    ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifid_instr = flow_instr[i];
      ifid_pcaddr = flow_pc[i];
      #1;
      if (i > 0) check("flow pre-edge", 64'(ifid_instr_out), 64'(flow_instr[i-1]));
      tick();
      check("flow instr", 64'(ifid_instr_out), 64'(flow_instr[i]));
      check("flow pc", ifid_pcaddr_out, flow_pc[i]);
      @(negedge clk);
    end

    // Short reset pulse mid-operation, then fresh load on the next edge
    idex_rd1 = 64'hCAFE; exmem_addr = 64'hBEEF;
    tick();
    check("mid preload idex", idex_rd1_out, 64'hCAFE);
    @(negedge clk);
    ifid_instr = 32'h8B020020; ifid_pcaddr = 64'h200;
    idex_rd1 = 64'h3C; exmem_aluresult = 64'h5A;
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("pulse_rst");
    #1;
    rst = 1'b0;
    #1;
    check("post-rst pre-edge", ifid_pcaddr_out, 64'h0);
    tick();
    check("fresh ifid_instr", 64'(ifid_instr_out), 64'h000000008B020020);
    check("fresh ifid_pc", ifid_pcaddr_out, 64'h200);
    check("fresh idex_rd1", idex_rd1_out, 64'h3C);
    check("fresh exmem_alu", exmem_aluresult_out, 64'h5A);
    check("fresh exmem_addr", exmem_addr_out, 64'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_regs.md
Name: pipeline_stage_regs

Overview:
- Bundles the three forward pipeline boundary registers of the 5-stage 64-bit ARM-subset CPU: IF/ID, ID/EX and EX/MEM.
- Each group is a bank of edge-triggered D registers with its own enable (stall) input.
- The group outputs feed the decode, execute and memory stages respectively.
- Purely sequential: no combinational path from any input to any output.

Parameters:
- DATA_W, 64, width of datapath words (PC, register data, immediates, ALU result, branch address).
- INSTR_W, 32, instruction width.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  single clock; all capture on rising edge.
- rst  in  1  asynchronous, active-high reset; clears every register.
- ifid_en  in  1  IF/ID capture enable.
- ifid_instr  in  INSTR_W  fetched instruction.
- ifid_pcaddr  in  DATA_W  PC of fetched instruction.
- ifid_instr_out  out  INSTR_W  registered instruction.
- ifid_pcaddr_out  out  DATA_W  registered PC.
- idex_en  in  1  ID/EX capture enable.
- idex_rd1, idex_rd2  in  DATA_W each  operand A/B after forwarding.
- idex_pcaddr  in  DATA_W  PC.
- idex_se  in  DATA_W  sign-extended immediate.
- idex_rn, idex_rm, idex_rd  in  REG_W each  register indices.
- idex_cntrl_ex  in  6  {FlagEn, ShiftDir, ALUsrc, ALUOp[2:0]} (bit5..0).
- idex_cntrl_m  in  5  {Brsel, Branch, UBranch, MemWrite, MemRead} (bit4..0).
- idex_cntrl_wb  in  2  {RegWrite, MemtoReg} (bit1..0).
- idex_*_out  out  same widths  registered copies of each idex input above (rd1, rd2, pcaddr, se, rn, rm, rd, cntrl_ex, cntrl_m, cntrl_wb).
- exmem_en  in  1  EX/MEM capture enable.
- exmem_aluresult, exmem_writedata, exmem_addr  in  DATA_W each  ALU result, store data, branch target.
- exmem_rd  in  REG_W  destination register.
- exmem_wb  in  2  WB controls.
- exmem_m  in  5  MEM controls.
- exmem_alu_flag  in  4  {zero, negative, overflow, carry} from ALU this cycle.
- exmem_flag  in  4  {zero, negative, overflow, carry} from flag register.
- exmem_*_out  out  same widths  registered copies of each exmem input above.

Behaviour:
- rst=1 (asynchronous, independent of clk or enables): every output goes to 0 immediately and holds 0 while rst is high.
  - A zero instruction word and all-zero control fields make the slot a bubble: no RegWrite, MemWrite, MemRead or branch.
- rst falling: nothing changes until the next rising clk edge.
- Rising clk, rst=0, group enable=1: every output in that group takes its input value sampled at the edge. Latency is exactly 1 cycle.
- Rising clk, group enable=0: that group holds its previous values.
- Groups are fully independent. Any combination of enables is legal.
- Simultaneous data change at the edge uses the pre-edge value (standard non-blocking capture).
- Fields are stored bit-exact, with no width conversion, sign extension or truncation.
- Bit positions within the control and flag buses are preserved exactly as listed under Ports.
- There is no flush input. Bubbles are created by the upstream stage driving zero controls.

Test Plan:
- Reset: drive random nonzero inputs, all enables=1, assert rst between clock edges → every output is 0 within the same timestep, before any clk edge. Outputs remain 0 across 2 edges while rst=1.
- IF/ID capture: rst=0, ifid_en=1, instr=32'hF8400041, pcaddr=64'h10. After one rising edge → ifid_instr_out=32'hF8400041 and ifid_pcaddr_out=64'h10. Not visible before that edge.
- ID/EX capture and stall:
  - Load rd1=64'd5, rd2=64'hFFFF_FFFF_FFFF_FFFB, se=64'h8, rn=1, rm=2, rd=3, cntrl_ex=6'b101010, cntrl_m=5'b10100, cntrl_wb=2'b10 → all appear after one edge.
  - Then set idex_en=0 and change every input → outputs unchanged for 3 edges.
- EX/MEM flag ordering: alu_flag=4'b1010, flag=4'b0101, aluresult=64'h20, addr=64'h40, rd=31, m=5'b00010, wb=2'b00 → after one edge, alu_flag_out=4'b1010, flag_out=4'b0101, other outputs equal inputs.
- Pipeline flow: apply a new IF/ID input every cycle for 5 cycles with all enables=1 → each output sequence lags its input by exactly one cycle. Consecutive distinct values are not merged or dropped.
- Reset mid-operation: after loading nonzero values in all groups, pulse rst for less than one clock period between edges → outputs clear immediately. The next edge with enable=1 loads the fresh inputs.
